// File: rtl/status_bits_pkg.sv
// Shared definitions for the multiplier status-word monitor: bit map, rule pairs, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package status_bits_pkg;

    typedef logic [2:0] bit_idx_t;

    localparam bit_idx_t ZERO_B    = 3'd0;
    localparam bit_idx_t INF_B     = 3'd1;
    localparam bit_idx_t NAN_B     = 3'd2;
    localparam bit_idx_t TINY_B    = 3'd3;
    localparam bit_idx_t HUGE_B    = 3'd4;
    localparam bit_idx_t INEXACT_B = 3'd5;

    localparam int NUM_RULES = 8;

    // Rule r is violated when status bits RULE_A[r] and RULE_B[r] are both set.
    localparam bit_idx_t RULE_A [NUM_RULES] = '{
        ZERO_B, ZERO_B, ZERO_B, INF_B, NAN_B, NAN_B, NAN_B,     TINY_B
    };
    localparam bit_idx_t RULE_B [NUM_RULES] = '{
        INF_B,  NAN_B,  HUGE_B, TINY_B, TINY_B, HUGE_B, INEXACT_B, HUGE_B
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } mon_state_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/status_rule_eval.sv
// Flags every illegal status-bit pair of one lane's 8-bit status word.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module status_rule_eval
    import status_bits_pkg::*;
(
    input  logic [7:0]           status,
    input  logic [NUM_RULES-1:0] rule_en,
    output logic [NUM_RULES-1:0] viol
);

    // Reserved bits [7:6] carry no meaning for any rule.
    logic unused_rsvd;
    assign unused_rsvd = ^status[7:6];

    for (genvar r = 0; r < NUM_RULES; r++) begin : g_rule
        assign viol[r] = rule_en[r] & status[RULE_A[r]] & status[RULE_B[r]];
    end

endmodule

// File: rtl/status_bits_monitor.sv
// Checks NUM_CH multiplier status words for illegal bit pairs; sticky flags, saturating counters, first-failure capture.
// Latency: status in cycle N -> flags/counters/capture updated at edge N+2.
// Backpressure: none; input is observed every cycle, ignored outside RUN.
module status_bits_monitor
    import status_bits_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 8,
    parameter int TS_W        = 16,
    parameter bit STOP_ON_ERR = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arm_i,
    input  logic                         clr_i,
    input  logic [NUM_RULES-1:0]         rule_en_i,
    input  logic [NUM_CH-1:0]            valid_i,
    input  logic [NUM_CH*8-1:0]          status_i,
    output logic [1:0]                   state_o,
    output logic [NUM_RULES-1:0]         err_o,
    output logic                         any_err_o,
    output logic [NUM_RULES*CNT_W-1:0]   viol_cnt_o,
    output logic [2:0]                   first_rule_o,
    output logic [ch_w(NUM_CH)-1:0]      first_ch_o,
    output logic [7:0]                   first_status_o,
    output logic [TS_W-1:0]              first_time_o
);

    localparam int              CH_W    = ch_w(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TS_W-1:0]  TS_MAX  = '1;

    mon_state_t                         state_q, state_d;
    logic                               in_run;
    logic [TS_W-1:0]                    ts_q;
    logic [NUM_CH-1:0]                  s1_vld_q;
    logic [NUM_CH*8-1:0]                s1_status_q;
    logic [TS_W-1:0]                    s1_ts_q;
    logic [NUM_CH-1:0][NUM_RULES-1:0]   lane_viol;
    logic [NUM_RULES-1:0]               fire;
    logic [NUM_RULES-1:0]               err_q;
    logic [NUM_RULES-1:0][CNT_W-1:0]    cnt_q;
    logic [2:0]                         cap_rule;
    logic [CH_W-1:0]                    cap_ch;
    logic [7:0]                         cap_status;

    assign in_run = (state_q == ST_RUN);

    // Stage 1: only lanes seen while running are qualified; the timestamp travels with the data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q    <= '0;
            s1_status_q <= '0;
            s1_ts_q     <= '0;
        end else begin
            s1_vld_q    <= in_run ? valid_i : '0;
            s1_status_q <= status_i;
            s1_ts_q     <= ts_q;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        status_rule_eval u_eval (
            .status  (s1_status_q[8*c +: 8]),
            .rule_en (rule_en_i & {NUM_RULES{s1_vld_q[c]}}),
            .viol    (lane_viol[c])
        );
    end

    // Stage 2 evaluation; stage-1 data is void once the block has left RUN.
    always_comb begin
        fire = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            fire = fire | lane_viol[c];
        end
        if (!in_run) begin
            fire = '0;
        end
    end

    // Scan from the top so the lowest lane, then the lowest rule, is the final winner.
    always_comb begin
        cap_rule   = '0;
        cap_ch     = '0;
        cap_status = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            for (int r = NUM_RULES - 1; r >= 0; r--) begin
                if (lane_viol[c][r]) begin
                    cap_rule   = 3'(r);
                    cap_ch     = CH_W'(c);
                    cap_status = s1_status_q[8*c +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (arm_i && !clr_i) state_d = ST_RUN;
            ST_RUN: begin
                if (clr_i)                     state_d = ST_IDLE;
                else if (STOP_ON_ERR && |fire) state_d = ST_HALT;
            end
            ST_HALT: if (clr_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q           <= '0;
            err_q          <= '0;
            cnt_q          <= '0;
            first_rule_o   <= '0;
            first_ch_o     <= '0;
            first_status_o <= '0;
            first_time_o   <= '0;
        end else if (clr_i) begin
            ts_q           <= '0;
            err_q          <= '0;
            cnt_q          <= '0;
            first_rule_o   <= '0;
            first_ch_o     <= '0;
            first_status_o <= '0;
            first_time_o   <= '0;
        end else begin
            if (state_q == ST_IDLE && arm_i) begin
                ts_q <= '0;
            end else if (in_run && ts_q != TS_MAX) begin
                ts_q <= ts_q + 1'b1;
            end
            err_q <= err_q | fire;
            for (int r = 0; r < NUM_RULES; r++) begin
                if (fire[r] && cnt_q[r] != CNT_MAX) begin
                    cnt_q[r] <= cnt_q[r] + 1'b1;
                end
            end
            if (!any_err_o && |fire) begin
                first_rule_o   <= cap_rule;
                first_ch_o     <= cap_ch;
                first_status_o <= cap_status;
                first_time_o   <= s1_ts_q;
            end
        end
    end

    assign state_o    = state_q;
    assign err_o      = err_q;
    assign any_err_o  = |err_q;
    assign viol_cnt_o = cnt_q;

endmodule

// File: tb/tb_status_bits_monitor.sv
// Bench for status_bits_monitor: a halting instance and a free-running 2-bit-counter instance share stimulus.
// Both are compared against a rule-level reference model advanced once per clock.
module tb_status_bits_monitor;

    localparam int NI     = 2;
    localparam int TS_MAX = 65535;
    localparam int CMAX [NI] = '{255, 3};
    localparam bit STOP [NI] = '{1'b1, 1'b0};
    localparam int PAIR_MASK [8] = '{'h03, 'h05, 'h11, 'h0A, 'h0C, 'h14, 'h24, 'h18};

    logic        clk = 1'b0;
    logic        rst;
    logic        arm, clr;
    logic [7:0]  rule_en;
    logic [1:0]  valid;
    logic [15:0] status;

    logic [1:0]  st_a    [NI];
    logic [7:0]  err_a   [NI];
    logic        any_a   [NI];
    logic [2:0]  frule_a [NI];
    logic [0:0]  fch_a   [NI];
    logic [7:0]  fst_a   [NI];
    logic [15:0] ftime_a [NI];
    logic [63:0] cnt_h;
    logic [15:0] cnt_r;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_state [NI];
    int m_ts    [NI];
    bit m_err   [NI][8];
    int m_cnt   [NI][8];
    int m_frule [NI];
    int m_fch   [NI];
    int m_fst   [NI];
    int m_ftime [NI];
    bit p_vld   [NI][2];
    int p_st    [NI][2];
    int p_ts    [NI];

    always #5 clk = ~clk;

    status_bits_monitor #(.NUM_CH(2), .CNT_W(8), .TS_W(16), .STOP_ON_ERR(1'b1)) dut_h (
        .clk(clk), .rst(rst), .arm_i(arm), .clr_i(clr), .rule_en_i(rule_en),
        .valid_i(valid), .status_i(status), .state_o(st_a[0]), .err_o(err_a[0]),
        .any_err_o(any_a[0]), .viol_cnt_o(cnt_h), .first_rule_o(frule_a[0]),
        .first_ch_o(fch_a[0]), .first_status_o(fst_a[0]), .first_time_o(ftime_a[0])
    );

    status_bits_monitor #(.NUM_CH(2), .CNT_W(2), .TS_W(16), .STOP_ON_ERR(1'b0)) dut_r (
        .clk(clk), .rst(rst), .arm_i(arm), .clr_i(clr), .rule_en_i(rule_en),
        .valid_i(valid), .status_i(status), .state_o(st_a[1]), .err_o(err_a[1]),
        .any_err_o(any_a[1]), .viol_cnt_o(cnt_r), .first_rule_o(frule_a[1]),
        .first_ch_o(fch_a[1]), .first_status_o(fst_a[1]), .first_time_o(ftime_a[1])
    );

    function automatic int act_cnt(input int i, input int r);
        if (i == 0) return int'(cnt_h[r*8 +: 8]);
        return int'(cnt_r[r*2 +: 2]);
    endfunction

    function automatic logic [7:0] m_err_byte(input int i);
        logic [7:0] b;
        for (int r = 0; r < 8; r++) b[r] = m_err[i][r];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_state[i] = 0; m_ts[i] = 0; p_ts[i] = 0;
            m_frule[i] = 0; m_fch[i] = 0; m_fst[i] = 0; m_ftime[i] = 0;
            for (int r = 0; r < 8; r++) begin m_err[i][r] = 0; m_cnt[i][r] = 0; end
            for (int c = 0; c < 2; c++) begin p_vld[i][c] = 0; p_st[i][c] = 0; end
        end
    endtask

    // One clock of the monitor, stated in terms of rules and lanes.
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            bit fired [8];
            int fr, fc, os, ots;
            bit had_err;
            fr = -1; fc = -1; os = m_state[i]; ots = m_ts[i]; had_err = 0;
            for (int r = 0; r < 8; r++) begin fired[r] = 0; had_err |= m_err[i][r]; end
            if (os == 1) begin
                for (int c = 0; c < 2; c++) begin
                    for (int r = 0; r < 8; r++) begin
                        if (p_vld[i][c] && rule_en[r] && ((p_st[i][c] & PAIR_MASK[r]) == PAIR_MASK[r])) begin
                            fired[r] = 1;
                            if (fr < 0) begin fr = r; fc = c; end
                        end
                    end
                end
            end
            if (clr) begin
                m_state[i] = 0; m_ts[i] = 0;
                m_frule[i] = 0; m_fch[i] = 0; m_fst[i] = 0; m_ftime[i] = 0;
                for (int r = 0; r < 8; r++) begin m_err[i][r] = 0; m_cnt[i][r] = 0; end
            end else begin
                if (fr >= 0 && !had_err) begin
                    m_frule[i] = fr; m_fch[i] = fc; m_fst[i] = p_st[i][fc]; m_ftime[i] = p_ts[i];
                end
                for (int r = 0; r < 8; r++) begin
                    if (fired[r]) begin
                        m_err[i][r] = 1;
                        if (m_cnt[i][r] < CMAX[i]) m_cnt[i][r]++;
                    end
                end
                if (os == 0 && arm) m_ts[i] = 0;
                else if (os == 1 && m_ts[i] < TS_MAX) m_ts[i]++;
                if (os == 0 && arm) m_state[i] = 1;
                else if (os == 1 && fr >= 0 && STOP[i]) m_state[i] = 2;
            end
            for (int c = 0; c < 2; c++) begin
                p_vld[i][c] = (os == 1) && valid[c];
                p_st[i][c]  = int'(status[8*c +: 8]);
            end
            p_ts[i] = ots;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            if (!rst) model_reset(); else model_step();
            @(negedge clk);
        end
    endtask

    task automatic quiet();
        arm = 0; clr = 0; valid = '0; status = '0;
    endtask

    task automatic do_reset();
        quiet(); rule_en = '1; rst = 0; model_reset(); cyc(2); rst = 1; cyc(1);
    endtask

    task automatic do_arm();
        arm = 1; cyc(1); arm = 0;
    endtask

    task automatic test_reset();
        rst = 0; model_reset(); rule_en = '1;
        arm = 1; valid = 2'b11; status = 16'h0303;
        cyc(3);
        for (int i = 0; i < NI; i++) begin
            n_checks++; if (st_a[i] !== 2'd0) begin n_errors++; $display("FAIL reset_state inst%0d got %0d want 0", i, st_a[i]); end
            n_checks++; if (err_a[i] !== 8'h00 || any_a[i] !== 1'b0) begin n_errors++; $display("FAIL reset_err inst%0d got %0h/%0b want 0/0", i, err_a[i], any_a[i]); end
            n_checks++; if (frule_a[i] !== 3'd0 || fch_a[i] !== 1'b0 || fst_a[i] !== 8'h00 || ftime_a[i] !== 16'd0) begin
                n_errors++; $display("FAIL reset_capture inst%0d got %0d/%0d/%0h/%0d want all 0", i, frule_a[i], fch_a[i], fst_a[i], ftime_a[i]); end
        end
        n_checks++; if (cnt_h !== 64'd0 || cnt_r !== 16'd0) begin n_errors++; $display("FAIL reset_cnt got %0h/%0h want 0", cnt_h, cnt_r); end
        rst = 1; quiet(); cyc(2);
        n_checks++; if (st_a[0] !== 2'd0) begin n_errors++; $display("FAIL reset_stays_idle got %0d want 0", st_a[0]); end
    endtask

    task automatic test_legal();
        logic [7:0] legal [5] = '{8'h01, 8'h22, 8'h04, 8'hC1, 8'hE1};
        do_reset(); do_arm();
        repeat (20) begin
            valid = 2'b11;
            for (int c = 0; c < 2; c++) status[8*c +: 8] = legal[$urandom_range(0, 4)];
            cyc(1);
        end
        quiet(); cyc(2);
        for (int i = 0; i < NI; i++) begin
            n_checks++; if (st_a[i] !== 2'd1) begin n_errors++; $display("FAIL legal_state inst%0d got %0d want 1", i, st_a[i]); end
            n_checks++; if (err_a[i] !== 8'h00) begin n_errors++; $display("FAIL legal_err inst%0d got %0h want 0", i, err_a[i]); end
            for (int r = 0; r < 8; r++) begin
                n_checks++; if (act_cnt(i, r) != 0) begin n_errors++; $display("FAIL legal_cnt inst%0d r%0d got %0d want 0", i, r, act_cnt(i, r)); end
            end
        end
    endtask

    task automatic test_stop_on_err();
        do_reset(); do_arm(); cyc(5);
        valid = 2'b10; status = 16'h0300;
        cyc(1);
        cyc(1);
        quiet();
        n_checks++; if (err_a[0] !== 8'h01) begin n_errors++; $display("FAIL halt_err got %0h want 01", err_a[0]); end
        n_checks++; if (frule_a[0] !== 3'd0 || fch_a[0] !== 1'b1) begin n_errors++; $display("FAIL halt_first_rule_ch got %0d/%0d want 0/1", frule_a[0], fch_a[0]); end
        n_checks++; if (fst_a[0] !== 8'h03) begin n_errors++; $display("FAIL halt_first_status got %0h want 03", fst_a[0]); end
        n_checks++; if (ftime_a[0] !== 16'd5) begin n_errors++; $display("FAIL halt_first_time got %0d want 5", ftime_a[0]); end
        n_checks++; if (st_a[0] !== 2'd2) begin n_errors++; $display("FAIL halt_state got %0d want 2", st_a[0]); end
        n_checks++; if (st_a[1] !== 2'd1 || ftime_a[1] !== 16'd5) begin n_errors++; $display("FAIL run_state_time got %0d/%0d want 1/5", st_a[1], ftime_a[1]); end
        cyc(3);
        n_checks++; if (act_cnt(0, 0) != 1) begin n_errors++; $display("FAIL halt_discard_cnt got %0d want 1", act_cnt(0, 0)); end
        n_checks++; if (act_cnt(1, 0) != 2) begin n_errors++; $display("FAIL run_cnt got %0d want 2", act_cnt(1, 0)); end
        arm = 1; cyc(1); arm = 0;
        n_checks++; if (st_a[0] !== 2'd2) begin n_errors++; $display("FAIL halt_arm_ignored got %0d want 2", st_a[0]); end
    endtask

    task automatic test_run_mode();
        do_reset(); do_arm();
        valid = 2'b11; status = 16'h1414; cyc(3); quiet(); cyc(2);
        n_checks++; if (act_cnt(1, 5) != 3) begin n_errors++; $display("FAIL run_r5_cnt got %0d want 3", act_cnt(1, 5)); end
        n_checks++; if (err_a[1] !== 8'h20 || st_a[1] !== 2'd1) begin n_errors++; $display("FAIL run_r5_err_state got %0h/%0d want 20/1", err_a[1], st_a[1]); end
        n_checks++; if (act_cnt(0, 5) != 1 || st_a[0] !== 2'd2) begin n_errors++; $display("FAIL halt_r5 got %0d/%0d want 1/2", act_cnt(0, 5), st_a[0]); end
        do_reset(); do_arm();
        valid = 2'b11; status = 16'h0C03; cyc(1); quiet(); cyc(2);
        for (int i = 0; i < NI; i++) begin
            n_checks++; if (fch_a[i] !== 1'b0 || frule_a[i] !== 3'd0 || fst_a[i] !== 8'h03) begin
                n_errors++; $display("FAIL prio_lane0_r0 inst%0d got ch%0d r%0d st%0h want ch0 r0 st03", i, fch_a[i], frule_a[i], fst_a[i]); end
            n_checks++; if (err_a[i] !== 8'h11) begin n_errors++; $display("FAIL prio_err inst%0d got %0h want 11", i, err_a[i]); end
        end
        do_reset(); do_arm();
        valid = 2'b11; status = 16'h030C; cyc(1); quiet(); cyc(2);
        n_checks++; if (fch_a[1] !== 1'b0 || frule_a[1] !== 3'd4 || fst_a[1] !== 8'h0C) begin
            n_errors++; $display("FAIL prio_lane_over_rule got ch%0d r%0d st%0h want ch0 r4 st0c", fch_a[1], frule_a[1], fst_a[1]); end
    endtask

    task automatic test_saturate();
        do_reset(); do_arm();
        valid = 2'b01; status = 16'h0018; cyc(5); quiet(); cyc(2);
        n_checks++; if (act_cnt(1, 7) != 3) begin n_errors++; $display("FAIL sat_r7 got %0d want 3", act_cnt(1, 7)); end
        n_checks++; if (err_a[1] !== 8'h80) begin n_errors++; $display("FAIL sat_err got %0h want 80", err_a[1]); end
        n_checks++; if (act_cnt(0, 7) != 1) begin n_errors++; $display("FAIL sat_halt_r7 got %0d want 1", act_cnt(0, 7)); end
    endtask

    task automatic test_rule_en();
        do_reset(); do_arm();
        rule_en = 8'hEF; valid = 2'b11; status = 16'h0C0C; cyc(3); quiet(); cyc(2);
        for (int i = 0; i < NI; i++) begin
            n_checks++; if (err_a[i] !== 8'h00 || act_cnt(i, 4) != 0 || st_a[i] !== 2'd1) begin
                n_errors++; $display("FAIL ruleen_off inst%0d got err%0h cnt%0d st%0d want 0/0/1", i, err_a[i], act_cnt(i, 4), st_a[i]); end
        end
        rule_en = 8'hFF; valid = 2'b11; status = 16'h0C0C; cyc(2); quiet(); cyc(2);
        n_checks++; if (act_cnt(1, 4) != 2 || err_a[1] !== 8'h10) begin n_errors++; $display("FAIL ruleen_on got cnt%0d err%0h want 2/10", act_cnt(1, 4), err_a[1]); end
        n_checks++; if (act_cnt(0, 4) != 1 || st_a[0] !== 2'd2) begin n_errors++; $display("FAIL ruleen_on_halt got cnt%0d st%0d want 1/2", act_cnt(0, 4), st_a[0]); end
    endtask

    task automatic test_clr_collision();
        do_reset(); do_arm();
        valid = 2'b01; status = 16'h0003; cyc(1);
        clr = 1; cyc(1); quiet(); cyc(2);
        for (int i = 0; i < NI; i++) begin
            n_checks++; if (st_a[i] !== 2'd0 || err_a[i] !== 8'h00 || any_a[i] !== 1'b0) begin
                n_errors++; $display("FAIL clr_collision inst%0d got st%0d err%0h any%0b want 0/0/0", i, st_a[i], err_a[i], any_a[i]); end
            n_checks++; if (act_cnt(i, 0) != 0 || ftime_a[i] !== 16'd0 || fst_a[i] !== 8'h00) begin
                n_errors++; $display("FAIL clr_collision_cap inst%0d got cnt%0d t%0d st%0h want 0", i, act_cnt(i, 0), ftime_a[i], fst_a[i]); end
        end
    endtask

    task automatic test_arm_clr();
        do_reset(); do_arm(); cyc(2);
        arm = 1; clr = 1; cyc(1); quiet();
        n_checks++; if (st_a[0] !== 2'd0 || st_a[1] !== 2'd0) begin n_errors++; $display("FAIL armclr_run got %0d/%0d want 0/0", st_a[0], st_a[1]); end
        arm = 1; clr = 1; cyc(1); quiet();
        n_checks++; if (st_a[1] !== 2'd0) begin n_errors++; $display("FAIL armclr_idle got %0d want 0", st_a[1]); end
        do_arm();
        n_checks++; if (st_a[1] !== 2'd1) begin n_errors++; $display("FAIL rearm got %0d want 1", st_a[1]); end
    endtask

    task automatic test_rst_mid();
        do_reset(); do_arm();
        valid = 2'b11; status = 16'h1803; cyc(3); quiet();
        rst = 0; model_reset(); #2;
        for (int i = 0; i < NI; i++) begin
            n_checks++; if (st_a[i] !== 2'd0 || err_a[i] !== 8'h00 || any_a[i] !== 1'b0 || ftime_a[i] !== 16'd0 || fst_a[i] !== 8'h00) begin
                n_errors++; $display("FAIL rst_mid inst%0d got st%0d err%0h any%0b t%0d s%0h want 0", i, st_a[i], err_a[i], any_a[i], ftime_a[i], fst_a[i]); end
        end
        n_checks++; if (cnt_h !== 64'd0 || cnt_r !== 16'd0) begin n_errors++; $display("FAIL rst_mid_cnt got %0h/%0h want 0", cnt_h, cnt_r); end
        @(negedge clk); rst = 1; cyc(1);
        do_arm(); valid = 2'b01; status = 16'h0003; cyc(1); quiet(); cyc(2);
        n_checks++; if (act_cnt(1, 0) != 1 || err_a[1] !== 8'h01) begin n_errors++; $display("FAIL rst_restart got cnt%0d err%0h want 1/01", act_cnt(1, 0), err_a[1]); end
    endtask

    task automatic test_random();
        logic [7:0] legal [6] = '{8'h01, 8'h02, 8'h22, 8'h21, 8'hC4, 8'h30};
        do_reset();
        repeat (600) begin
            arm = ($urandom_range(0, 19) == 0);
            clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) rule_en = 8'($urandom);
            valid = 2'($urandom);
            for (int c = 0; c < 2; c++)
                status[8*c +: 8] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : legal[$urandom_range(0, 5)];
            cyc(1);
            for (int i = 0; i < NI; i++) begin
                n_checks++; if (int'(st_a[i]) != m_state[i]) begin n_errors++; $display("FAIL rnd_state inst%0d got %0d want %0d", i, st_a[i], m_state[i]); end
                n_checks++; if (err_a[i] !== m_err_byte(i) || any_a[i] !== (|m_err_byte(i))) begin
                    n_errors++; $display("FAIL rnd_err inst%0d got %0h want %0h", i, err_a[i], m_err_byte(i)); end
                for (int r = 0; r < 8; r++) begin
                    n_checks++; if (act_cnt(i, r) != m_cnt[i][r]) begin n_errors++; $display("FAIL rnd_cnt inst%0d r%0d got %0d want %0d", i, r, act_cnt(i, r), m_cnt[i][r]); end
                end
                n_checks++; if (int'(frule_a[i]) != m_frule[i] || int'(fch_a[i]) != m_fch[i] || int'(fst_a[i]) != m_fst[i] || int'(ftime_a[i]) != m_ftime[i]) begin
                    n_errors++; $display("FAIL rnd_first inst%0d got r%0d c%0d s%0h t%0d want r%0d c%0d s%0h t%0d", i,
                        frule_a[i], fch_a[i], fst_a[i], ftime_a[i], m_frule[i], m_fch[i], m_fst[i], m_ftime[i]); end
            end
        end
        quiet();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; rule_en = '1; quiet(); model_reset();
        test_reset();
        test_legal();
        test_stop_on_err();
        test_run_mode();
        test_saturate();
        test_rule_en();
        test_clr_collision();
        test_arm_clr();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
